curve_engine_seq: RTL and testbench

Microcode sequencer sitting directly upstream of the curve engine execution unit.
- Fetches instruction words from a synchronous microcode RAM and resolves control-flow opcodes (jump, loop, finish) locally.
- Issues all remaining opcodes to the execution unit over a valid/ready handshake.
- Reports completion via a done pulse, which the simulation bench uses to drive its success/done/report signals.

---
 rtl/curve_engine_seq.sv | 197 +++++++++++++++++++
 tb/tb_curve_engine_seq.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/curve_engine_seq.sv
// curve_engine_seq: microcode sequencer feeding the curve engine execution unit.
// Build option: define CURVE_ENGINE_SEQ_STEP_EN to add single-step hold (step_en/step).
module curve_engine_seq #(
    parameter int UCODE_AW = 10,
    parameter int INSN_W   = 32,
    parameter int LOOP_W   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [UCODE_AW-1:0] start_pc,
    output logic [UCODE_AW-1:0] ucode_addr,
    output logic                ucode_rd,
    input  logic [INSN_W-1:0]   ucode_data,
    output logic                issue_valid,
    output logic [INSN_W-1:0]   issue_insn,
    input  logic                issue_ready,
    input  logic                exec_idle,
`ifdef CURVE_ENGINE_SEQ_STEP_EN
    input  logic                step_en,
    input  logic                step,
`endif
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [UCODE_AW-1:0] pc
);

    localparam logic [5:0] OP_JMP  = 6'h20;
    localparam logic [5:0] OP_LOOP = 6'h21;
    localparam logic [5:0] OP_BRNZ = 6'h22;
    localparam logic [5:0] OP_FIN  = 6'h3F;

`ifdef CURVE_ENGINE_SEQ_STEP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_DRAIN, S_DONE, S_HOLD
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_DRAIN, S_DONE
    } state_t;
`endif

    state_t              r_state;
    logic [UCODE_AW-1:0] r_pc;
    logic [LOOP_W-1:0]   r_ctr;
    logic [INSN_W-1:0]   r_insn;
    logic                r_rd;
    logic                r_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    logic [5:0]          w_op;
    logic [LOOP_W-1:0]   w_imm;
    logic [UCODE_AW-1:0] w_target;
    logic [UCODE_AW-1:0] w_pc_inc;
    logic                w_pc_last;

    assign w_op      = ucode_data[5:0];
    assign w_imm     = ucode_data[8+LOOP_W-1:8];
    assign w_target  = ucode_data[INSN_W-1:INSN_W-UCODE_AW];
    assign w_pc_inc  = r_pc + 1'b1;
    assign w_pc_last = &r_pc;

    assign ucode_addr  = r_pc;
    assign ucode_rd    = r_rd;
    assign issue_valid = r_valid;
    assign issue_insn  = r_insn;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign pc          = r_pc;

    // Sequencer FSM: fetch, resolve control flow locally, issue the rest.
    // Sequential advance past the last address aborts with error instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ctr   <= '0;
            r_insn  <= '0;
            r_rd    <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_rd   <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc    <= start_pc;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_rd    <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_insn <= ucode_data;
                    case (w_op)
                        OP_JMP: begin
                            r_pc    <= w_target;
                            r_rd    <= 1'b1;
                            r_state <= S_FETCH;
                        end
                        OP_LOOP: begin
                            r_ctr <= w_imm;
                            if (w_pc_last) begin
                                r_error <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_pc    <= w_pc_inc;
                                r_rd    <= 1'b1;
                                r_state <= S_FETCH;
                            end
                        end
                        OP_BRNZ: begin
                            if (r_ctr != '0) begin
                                r_ctr   <= r_ctr - 1'b1;
                                r_pc    <= w_target;
                                r_rd    <= 1'b1;
                                r_state <= S_FETCH;
                            end else if (w_pc_last) begin
                                r_error <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_pc    <= w_pc_inc;
                                r_rd    <= 1'b1;
                                r_state <= S_FETCH;
                            end
                        end
                        OP_FIN: begin
                            r_state <= S_DRAIN;
                        end
                        default: begin
`ifdef CURVE_ENGINE_SEQ_STEP_EN
                            if (step_en) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_valid <= 1'b1;
                                r_state <= S_ISSUE;
                            end
`else
                            r_valid <= 1'b1;
                            r_state <= S_ISSUE;
`endif
                        end
                    endcase
                end
`ifdef CURVE_ENGINE_SEQ_STEP_EN
                S_HOLD: begin
                    if (step) begin
                        r_valid <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
`endif
                S_ISSUE: begin
                    if (issue_ready) begin
                        r_valid <= 1'b0;
                        if (w_pc_last) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_pc    <= w_pc_inc;
                            r_rd    <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DRAIN: begin
                    if (exec_idle) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_curve_engine_seq.sv
// tb_curve_engine_seq: directed and random microcode programs checked
// against an instruction-level interpreter of the sequencer.
module tb_curve_engine_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  start_pc;
    logic [9:0]  ucode_addr;
    logic        ucode_rd;
    logic [31:0] ucode_data;
    logic        issue_valid;
    logic [31:0] issue_insn;
    logic        issue_ready;
    logic        exec_idle;
    logic        busy;
    logic        done;
    logic        error;
    logic [9:0]  pc;

    curve_engine_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_pc   (start_pc),
        .ucode_addr (ucode_addr),
        .ucode_rd   (ucode_rd),
        .ucode_data (ucode_data),
        .issue_valid(issue_valid),
        .issue_insn (issue_insn),
        .issue_ready(issue_ready),
        .exec_idle  (exec_idle),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [1024];

    // Synchronous microcode RAM: one cycle read latency.
    always @(posedge clk) begin
        if (ucode_rd) ucode_data <= mem[ucode_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          acc_cyc[$];
    int          exp_done;
    int          exp_err;
    int          m_ctr;
    int          valid_cnt;
    int          done_cnt;
    int          done_cyc;
    int          exit_cyc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] w;
        do w = $urandom;
        while (w[5:0] inside {6'h20, 6'h21, 6'h22, 6'h3F});
        return w;
    endfunction

    function automatic logic [31:0] mk_ctl(input logic [5:0] op,
                                           input logic [9:0] imm,
                                           input logic [9:0] tgt);
        logic [31:0] w;
        w = $urandom;
        w[5:0]   = op;
        w[17:8]  = imm;
        w[31:22] = tgt;
        return w;
    endfunction

    // Interpret the program word by word from spc; the loop counter persists.
    task automatic model(input logic [9:0] spc);
        logic [9:0]  p;
        logic [31:0] w;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        p = spc;
        for (int s = 0; s < 2000; s++) begin
            w = mem[p];
            if (w[5:0] == 6'h20) begin
                p = w[31:22];
            end else if (w[5:0] == 6'h21) begin
                m_ctr = int'(w[17:8]);
                if (p == 10'h3FF) begin exp_err = 1; break; end
                p = p + 10'd1;
            end else if (w[5:0] == 6'h22) begin
                if (m_ctr != 0) begin
                    m_ctr = m_ctr - 1;
                    p = w[31:22];
                end else begin
                    if (p == 10'h3FF) begin exp_err = 1; break; end
                    p = p + 10'd1;
                end
            end else if (w[5:0] == 6'h3F) begin
                exp_done = 1;
                break;
            end else begin
                exp_q.push_back(w);
                if (p == 10'h3FF) begin exp_err = 1; break; end
                p = p + 10'd1;
            end
        end
    endtask

    task automatic gen(input int base);
        int a;
        int nb;
        a  = base;
        nb = $urandom_range(1, 5);
        for (int b = 0; b < nb; b++) begin
            case ($urandom_range(0, 3))
                0: begin
                    mem[a] = rand_op();
                    a = a + 1;
                end
                1: begin
                    mem[a]   = mk_ctl(6'h21, 10'($urandom_range(0, 3)), 10'd0);
                    mem[a+1] = rand_op();
                    mem[a+2] = mk_ctl(6'h22, 10'd0, 10'(a + 1));
                    a = a + 3;
                end
                2: begin
                    mem[a]   = mk_ctl(6'h20, 10'd0, 10'(a + 2));
                    mem[a+1] = rand_op();
                    a = a + 2;
                end
                default: begin
                    mem[a]   = mk_ctl(6'h22, 10'd0, 10'(a + 2));
                    mem[a+1] = rand_op();
                    a = a + 2;
                end
            endcase
        end
        mem[a] = mk_ctl(6'h3F, 10'd0, 10'd0);
    endtask

    // Start a program, drive random ready/idle, collect accepted words.
    task automatic run(input logic [9:0] spc, input int rdy_pct,
                       input int idle_pct, input bit spur);
        int cyc;
        model(spc);
        obs_q.delete();
        acc_cyc.delete();
        valid_cnt = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        @(negedge clk);
        start    = 1'b1;
        start_pc = spc;
        @(negedge clk);
        start = 1'b0;
        check("err_clr", 32'(error), 32'd0);
        cyc = 0;
        while (busy && cyc < 4000) begin
            issue_ready = ($urandom_range(0, 99) < rdy_pct);
            exec_idle   = ($urandom_range(0, 99) < idle_pct);
            start       = spur && (cyc == 2);
            if (start) start_pc = 10'($urandom);
            if (issue_valid) valid_cnt++;
            if (issue_valid && issue_ready) begin
                obs_q.push_back(issue_insn);
                acc_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", 32'(busy), 32'd1);
            end
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        exit_cyc = cyc;
        check("timeout", 32'(cyc < 4000), 32'd1);
        check("n_issued", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check("insn", obs_q[i], exp_q[i]);
        check("done_cnt", 32'(done_cnt), 32'(exp_done));
        check("error", 32'(error), 32'(exp_err));
        if (exp_done != 0)
            check("busy_fall", 32'(exit_cyc - done_cyc), 32'd1);
    endtask

    initial begin
        int k;
        int good;
        rst         = 1'b1;
        start       = 1'b0;
        start_pc    = '0;
        issue_ready = 1'b0;
        exec_idle   = 1'b1;
        m_ctr       = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_003F;
        repeat (2) @(negedge clk);
        check("rst_ctl", 32'({ucode_rd, issue_valid, busy, done, error}), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_addr", 32'(ucode_addr), 32'd0);
        check("rst_insn", issue_insn, 32'd0);
        rst = 1'b0;

        // Straight line
        mem[5] = 32'h0000_0001;
        mem[6] = 32'h0000_0002;
        mem[7] = 32'h0000_003F;
        run(10'd5, 100, 100, 1'b0);
        check("straight_n", 32'(obs_q.size()), 32'd2);
        check("straight_vcyc", 32'(valid_cnt), 32'd2);
        if (acc_cyc.size() >= 2)
            check("straight_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        check("straight_done", 32'(done_cnt), 32'd1);

        // Loop of 3 -> body issued 4 times
        mem[0] = mk_ctl(6'h21, 10'd3, 10'd0);
        mem[1] = 32'h0000_0005;
        mem[2] = mk_ctl(6'h22, 10'd0, 10'd1);
        mem[3] = 32'h0000_003F;
        run(10'd0, 100, 100, 1'b0);
        check("loop_cnt", 32'(obs_q.size()), 32'd4);
        check("loop_done", 32'(done_cnt), 32'd1);

        // Counter left at zero: BRNZ falls through
        mem[8]  = mk_ctl(6'h22, 10'd0, 10'd10);
        mem[9]  = 32'h0000_0011;
        mem[10] = 32'h0000_003F;
        run(10'd8, 100, 100, 1'b0);
        check("ctr_zero", 32'(obs_q.size()), 32'd1);

        // Backpressure for 7 cycles
        mem[16] = 32'hABCD_E701;
        mem[17] = 32'h0000_003F;
        issue_ready = 1'b0;
        exec_idle   = 1'b1;
        @(negedge clk);
        start    = 1'b1;
        start_pc = 10'd16;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!issue_valid && k < 10) begin @(negedge clk); k++; end
        check("bp_reach", 32'(issue_valid), 32'd1);
        good = 0;
        for (int i = 0; i < 7; i++) begin
            if (issue_valid && issue_insn == 32'hABCD_E701 && pc == 10'd16)
                good++;
            @(negedge clk);
        end
        check("bp_stable", 32'(good), 32'd7);
        issue_ready = 1'b1;
        @(negedge clk);
        check("bp_drop", 32'(issue_valid), 32'd0);
        check("bp_pc", 32'(pc), 32'd17);
        k = 0;
        while (busy && k < 20) begin @(negedge clk); k++; end
        check("bp_end", 32'(busy), 32'd0);

        // Drain waits on exec_idle
        mem[32] = 32'h0000_003F;
        exec_idle = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        start_pc = 10'd32;
        @(negedge clk);
        start = 1'b0;
        good = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) good++;
            @(negedge clk);
        end
        exec_idle = 1'b1;
        if (done) good++;
        check("drain_early", 32'(good), 32'd0);
        @(negedge clk);
        check("drain_done", 32'(done), 32'd1);
        @(negedge clk);
        check("drain_idle", 32'({busy, done}), 32'd0);

        // PC overflow, then a start clears error
        mem[10'h3FF] = 32'h0000_0001;
        run(10'h3FF, 100, 100, 1'b0);
        check("ovf_err", 32'(error), 32'd1);
        check("ovf_busy", 32'(busy), 32'd0);
        check("ovf_n", 32'(obs_q.size()), 32'd1);
        run(10'd5, 100, 100, 1'b0);
        check("ovf_clear", 32'(error), 32'd0);

        // Asynchronous reset mid-ISSUE
        mem[48] = 32'h0000_0305;
        mem[49] = 32'h0000_003F;
        issue_ready = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        start_pc = 10'd48;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!issue_valid && k < 10) begin @(negedge clk); k++; end
        check("ar_reach", 32'(issue_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_ctl", 32'({ucode_rd, issue_valid, busy, done, error}), 32'd0);
        check("ar_pc", 32'({pc, ucode_addr}), 32'd0);
        check("ar_insn", issue_insn, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        m_ctr = 0;

        // Random programs with random handshakes and spurious starts
        for (int t = 0; t < 25; t++) begin
            k = $urandom_range(0, 1000);
            gen(k);
            run(10'(k), $urandom_range(20, 100), $urandom_range(20, 100), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
